// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, PC increment and prefetch FIFO entry type
// for the instruction fetch stage.
package fetch_unit_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch buffer of {pc, instr} entries; flush empties it
// and rewinds both pointers, which wrap modulo DEPTH.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    input  fetch_entry_t                  data_i,
    output fetch_entry_t                  head_o,
    output logic [$clog2(DEPTH):0]        count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_d = flush_i ? '0 : wr_q + PW'(push_i);
        rd_d = flush_i ? '0 : rd_q + PW'(pop_i);
        count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
        head_o = mem_q[rd_q];
        count_o = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end

    // Credit accounting upstream guarantees a push never meets a full buffer.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
        if (!rst) assert (!(push_i && count_q == CW'(DEPTH)));
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited pipelined instruction fetch with a prefetch FIFO
// toward decode and redirect-driven flush/discard of in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PC_W-1:0]    mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_base;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, count, resp_dec;
    logic [CW:0] credit_sum;
    logic accept, drop, push, pop;
    fetch_entry_t head, push_entry;

    always_comb begin
        redirect_base = redirect_pc & ~PC_W'(3);
        credit_sum = {1'b0, count} + {1'b0, outstanding_q};
        // Every outstanding request owns a FIFO slot, so responses always fit.
        mem_req_valid = !reset && !redirect && credit_sum < (CW+1)'(DEPTH);
        mem_req_addr = fetch_pc_q;
        accept = mem_req_valid && mem_req_ready;
        drop = mem_resp_valid && discard_q != '0;
        push = mem_resp_valid && !drop && !redirect;
        instr_valid = count != '0;
        pop = instr_valid && instr_ready && !redirect;
        instr = instr_valid ? head.instr : '0;
        instr_pc = instr_valid ? head.pc : '0;
        push_entry = '{pc: resp_pc_q, instr: mem_resp_data};
        resp_dec = CW'(mem_resp_valid);
        fetch_pc_d = redirect ? redirect_base : accept ? fetch_pc_q + PC_STEP : fetch_pc_q;
        resp_pc_d = redirect ? redirect_base : push ? resp_pc_q + PC_STEP : resp_pc_q;
        // On redirect every request still in flight becomes a response to drop.
        outstanding_d = redirect ? outstanding_q - resp_dec : outstanding_q + CW'(accept) - resp_dec;
        discard_d = redirect ? outstanding_q - resp_dec : discard_q - CW'(drop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outstanding_q <= '0;
            discard_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_i  (push_entry),
        .head_o  (head),
        .count_o (count)
    );
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle decode/execute core.
- Replaces the combinational instruction ROM lookup with a pipelined, latency-tolerant fetch against an instruction memory using a valid/ready request port and an in-order response port.
- Buffers fetched words in a small prefetch FIFO and presents them to decode with their PC under a valid/ready handshake.
- Supports control-flow redirect (jump/taken branch) with flush and discard of in-flight responses.

Parameters:
- DEPTH, 4, prefetch FIFO entries; also the maximum number of outstanding requests. Power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  out  1  request to instruction memory.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  32  word-aligned fetch address.
- mem_resp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- mem_resp_data  in  32  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes the head this cycle.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - occupancy=0, outstanding=0, discard=0, FIFO pointers=0.
  - mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Counter widths: occupancy, outstanding and discard are $clog2(DEPTH)+1 bits.
- Credit rule: mem_req_valid = !redirect && (occupancy + outstanding < DEPTH).
  - A response can therefore never find the FIFO full.
  - The request is accepted when mem_req_valid && mem_req_ready; fetch_pc then advances by 4 and outstanding increments.
- mem_req_addr = fetch_pc. Address and valid are held stable while the request is not accepted. fetch_pc wraps modulo 2^32.
- Response handling:
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise {resp_pc, data} is pushed into the FIFO and resp_pc increments by 4.
  - outstanding decrements on every response, dropped or not.
- Pop: on instr_valid && instr_ready the head is removed. instr and instr_pc come combinationally from the FIFO head. instr_valid = occupancy != 0.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
  - Occupancy of DEPTH with push is unreachable by construction; assert it in simulation.
- Redirect takes priority over everything in the same cycle:
  - FIFO is flushed: occupancy=0, pointers reset. A pop in the same cycle is ignored.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - discard = outstanding − (mem_resp_valid ? 1 : 0): a response arriving in the redirect cycle is itself dropped.
  - outstanding = discard (the new value).
  - Fetch restarts the following cycle.
- Redirect while discard > 0: the recomputation above still holds; discard never exceeds outstanding.
- Back-to-back redirects: the last one wins; the cycle count of pending discards stays correct.
- Throughput: with a 1-cycle memory and instr_ready held high, one instruction per cycle after 2 cycles of startup latency (request cycle, response cycle).
- Reset asserted mid-operation returns all state to reset values immediately. Responses still in flight in the memory after reset are the memory's responsibility: it is reset by the same signal.

Decomposition:
- Shared package:
  - INSTR_W=32, PC_W=32, PC_STEP=4.
  - A typedef for the FIFO entry struct {pc, instr}.
- One sub-module: fetch_fifo.
  - Parameterised circular buffer of DEPTH entries × 64 bits.
  - Ports: push, pop, flush, head data, occupancy.
  - Pointers wrap modulo DEPTH.
- Credit, discard and PC logic stay in fetch_unit.

Test Plan:
- Reset release, 1-cycle memory, instr_ready=1 → requests at addresses 0,4,8,…; instr_valid first high in cycle 2 with instr_pc=0, then one instruction per cycle in PC order.
- instr_ready=0, memory always ready → exactly 4 requests issued (0..12), FIFO fills with occupancy 4, mem_req_valid stays 0; raise instr_ready → pops 0,4,8,12 and fetch resumes at 16.
- 3-cycle response latency, 3 requests outstanding, redirect to 0x100 → the next 3 responses are dropped (never visible on instr); first delivered word has instr_pc=0x100.
- Redirect in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, discard = outstanding − 1, mem_req_valid low in the redirect cycle.
- redirect_pc=0x0000_0203 → mem_req_addr=0x0000_0200. fetch_pc at 0xFFFF_FFFC → next address 0x0000_0000.
- Assert reset while the FIFO holds 2 entries and 2 requests are outstanding → instr_valid=0 and mem_req_valid=0 immediately; after release, fetch restarts at RESET_PC.
